// File: rtl/tone_pkg.sv
// ============================================================================
// tone_pkg : shared widths, mute threshold and note frequencies for tone_synth
// Rev 1.0
// ============================================================================
`default_nettype none

package tone_pkg;

  localparam int unsigned DIV_W       = 32;
  localparam int unsigned MUTE_HZ_DEF = 20000;

  localparam logic [31:0] NOTE_LA   = 32'd220;
  localparam logic [31:0] NOTE_SI   = 32'd247;
  localparam logic [31:0] NOTE_DO   = 32'd262;
  localparam logic [31:0] NOTE_RE   = 32'd294;
  localparam logic [31:0] NOTE_MI   = 32'd330;
  localparam logic [31:0] NOTE_FA   = 32'd349;
  localparam logic [31:0] NOTE_SO   = 32'd392;
  localparam logic [31:0] NOTE_MUTE = 32'd20000;

  function automatic logic is_silent(input logic [31:0] freq, input logic [31:0] mute_hz);
    return (freq == '0) || (freq >= mute_hz);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
// seq_divider : restoring divider, one quotient bit per cycle, W cycles
// Rev 1.0
// ============================================================================
`default_nettype none

module seq_divider #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W:0]   divisor,
  output logic [W-1:0] quotient,
  output logic         busy,
  output logic         done
);

  localparam int unsigned CW = $clog2(W);

  logic [W-1:0]  r_acc;
  logic [W:0]    r_rem;
  logic [W:0]    r_div;
  logic [CW-1:0] r_cnt;

  logic [W+1:0]  w_trial;
  logic          w_ge;
  logic [W:0]    w_sub;

  // The difference is only kept when it is below the divisor, so W+1 bits
  // of modular subtraction are exact.
  assign w_trial  = {r_rem, r_acc[W-1]};
  assign w_ge     = w_trial >= {1'b0, r_div};
  assign w_sub    = w_trial[W:0] - r_div;
  assign quotient = {r_acc[W-2:0], w_ge};
  assign done     = busy && (r_cnt == CW'(W-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_rem <= '0;
      r_div <= '0;
      r_cnt <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      r_acc <= dividend;
      r_rem <= '0;
      r_div <= divisor;
      r_cnt <= '0;
      busy  <= 1'b1;
    end else if (busy) begin
      r_acc <= quotient;
      r_rem <= w_ge ? w_sub : w_trial[W:0];
      r_cnt <= r_cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/tone_synth.sv
// ============================================================================
// tone_synth : tone (Hz) to 50% square wave; TONE_SYNTH_AMP_EN adds signed pcm
// Rev 1.0
// ============================================================================
`default_nettype none

module tone_synth
  import tone_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned CNT_W   = 22,
  parameter int unsigned MUTE_HZ = MUTE_HZ_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        tone,
  input  logic               en,
`ifdef TONE_SYNTH_AMP_EN
  input  logic [14:0]        amp,
  output logic signed [15:0] pcm,
`endif
  output logic               audio_out,
  output logic               busy
);

  localparam logic [CNT_W-1:0] HALF_MAX = '1;

  logic [31:0]      tone_q;
  logic [CNT_W-1:0] half_q;
  logic [CNT_W-1:0] cnt;
  logic             mute;

  logic             w_changed;
  logic             w_silent;
  logic             w_start;
  logic             w_load;
  logic             w_mute_set;
  logic             w_play;
  logic             w_toggle;
  logic             w_audio_next;
  logic [CNT_W-1:0] w_sat;

  logic [DIV_W-1:0] div_quo;
  logic             div_busy;
  logic             div_done;

  assign w_changed = tone != tone_q;
  assign w_silent  = is_silent(tone, 32'(MUTE_HZ));
  assign w_start   = w_changed && !w_silent;
  assign w_load    = !w_changed && busy && div_busy && div_done;
  assign w_sat     = (div_quo > 32'(HALF_MAX)) ? HALF_MAX : div_quo[CNT_W-1:0];

  // Entering mute silences the output on the same edge; leaving mute only
  // starts counting on the following edge so the first high comes half_q later.
  assign w_mute_set   = (w_changed && w_silent) || (w_load && (div_quo == '0));
  assign w_play       = en && !mute && !w_mute_set;
  assign w_toggle     = ({1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1}) >= {1'b0, half_q};
  assign w_audio_next = w_toggle ? ~audio_out : audio_out;

  seq_divider #(
    .W (DIV_W)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (w_start),
    .dividend (DIV_W'(CLK_HZ)),
    .divisor  ({tone, 1'b0}),
    .quotient (div_quo),
    .busy     (div_busy),
    .done     (div_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tone_q <= '0;
      half_q <= '0;
      mute   <= 1'b1;
      busy   <= 1'b0;
    end else if (w_changed) begin
      tone_q <= tone;
      busy   <= w_start;
      if (w_silent) mute <= 1'b1;
    end else if (w_load) begin
      busy <= 1'b0;
      if (div_quo == '0) begin
        mute <= 1'b1;
      end else begin
        mute   <= 1'b0;
        half_q <= w_sat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      audio_out <= 1'b0;
    end else if (!w_play) begin
      cnt       <= '0;
      audio_out <= 1'b0;
    end else begin
      cnt       <= w_toggle ? '0 : cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      audio_out <= w_audio_next;
    end
  end

`ifdef TONE_SYNTH_AMP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       pcm <= '0;
    else if (!w_play) pcm <= '0;
    else              pcm <= w_audio_next ? $signed({1'b0, amp}) : -$signed({1'b0, amp});
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_tone_synth.sv
// ============================================================================
// tb_tone_synth : directed bench for tone_synth at CLK_HZ = 1 MHz
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_tone_synth;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] tone = '0;
  logic        en = 1'b0;
  logic        audio_out, busy;
  logic        audio_q0, busy_q0;
`ifdef TONE_SYNTH_AMP_EN
  logic [14:0]        amp = 15'd1000;
  logic signed [15:0] pcm, pcm_q0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tone_synth #(.CLK_HZ(1_000_000), .CNT_W(18), .MUTE_HZ(20000)) dut (
    .clk(clk), .rst_n(rst_n), .tone(tone), .en(en),
`ifdef TONE_SYNTH_AMP_EN
    .amp(amp), .pcm(pcm),
`endif
    .audio_out(audio_out), .busy(busy)
  );

  // Raised mute threshold so a tone of 600000 reaches the divider.
  tone_synth #(.CLK_HZ(1_000_000), .CNT_W(18), .MUTE_HZ(1_000_000)) u_q0 (
    .clk(clk), .rst_n(rst_n), .tone(tone), .en(en),
`ifdef TONE_SYNTH_AMP_EN
    .amp(amp), .pcm(pcm_q0),
`endif
    .audio_out(audio_q0), .busy(busy_q0)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
  endtask

  task automatic count_until(input logic val, output int n);
    n = 0;
    while (audio_out !== val && n < 300000) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    int n2;
    logic seen_bad;
    logic any_hi;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_audio", audio_out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_half", dut.half_q, 0);
    chk("reset_tone_q", dut.tone_q, 0);

    // Release with 262 Hz present
    rst_n = 1'b1; tone = 32'd262; en = 1'b1;
    count_busy(n);
    chk("busy_262", n, 32);
    chk("half_262", dut.half_q, 1908);
    chk("audio_after_load", audio_out, 0);
    count_until(1'b1, n);
    chk("first_rise_262", n, 1908);
`ifdef TONE_SYNTH_AMP_EN
    chk("pcm_pos", pcm, 1000);
`endif
    count_until(1'b0, n);
    chk("high_time_262", n, 1908);
`ifdef TONE_SYNTH_AMP_EN
    chk("pcm_neg", pcm, -1000);
`endif
    count_until(1'b1, n);
    chk("low_time_262", n, 1908);

    // 262 -> 330 mid-period: old waveform holds through the division
    repeat (500) @(negedge clk);
    tone = 32'd330;
    count_busy(n);
    chk("busy_330", n, 32);
    chk("audio_held_330", audio_out, 1);
    chk("half_330", dut.half_q, 1515);
    count_until(1'b0, n);
    chk("toggle_within_330", (n >= 1 && n <= 1515), 1);
    count_until(1'b1, n);
    chk("low_time_330", n, 1515);

    // Mute codes silence at the accepting edge
    tone = 32'd20000;
    @(negedge clk);
    chk("mute20000_audio", audio_out, 0);
    chk("mute20000_busy", busy, 0);
    tone = 32'd0;
    @(negedge clk);
    chk("mute0_audio", audio_out, 0);
    chk("mute0_busy", busy, 0);
    repeat (100) @(negedge clk);
    chk("mute0_still", audio_out, 0);
    tone = 32'd220;
    count_busy(n);
    chk("busy_220", n, 32);
    chk("half_220", dut.half_q, 2272);
    count_until(1'b1, n);
    chk("first_rise_220", n, 2272);

    // Quotient zero mutes (u_q0); 600000 is a mute code for dut
    tone = 32'd600000;
    n2 = 0; any_hi = 1'b0; seen_bad = 1'b0;
    while (n2 < 200) begin
      @(negedge clk);
      if (audio_out || busy) seen_bad = 1'b1;
      if (!busy_q0) break;
      n2++;
    end
    chk("q0_busy", n2, 32);
    chk("dut_600000_silent", seen_bad, 0);
    chk("q0_audio", audio_q0, 0);
    repeat (2500) begin
      @(negedge clk);
      if (audio_q0) any_hi = 1'b1;
    end
    chk("q0_stays_silent", any_hi, 0);

    // tone = 1 saturates to 2^18-1
    tone = 32'd1;
    count_busy(n);
    chk("busy_1", n, 32);
    chk("sat_half", dut.half_q, 262143);
    chk("sat_half_q0", u_q0.half_q, 262143);

    // 247 -> 294 five cycles apart: only 1700 is ever loaded
    tone = 32'd247;
    seen_bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (dut.half_q != 18'd262143) seen_bad = 1'b1;
    end
    tone = 32'd294;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (dut.half_q != 18'd262143 && dut.half_q != 18'd1700) seen_bad = 1'b1;
      if (!busy) break;
      n++;
    end
    chk("busy_294_restart", n, 32);
    chk("only_1700_loaded", seen_bad, 0);
    chk("half_294", dut.half_q, 1700);
    count_until(1'b1, n);
    chk("toggle_within_294", (n >= 1 && n <= 1700), 1);
    count_until(1'b0, n);
    chk("high_time_294", n, 1700);

    // en low silences; resuming rises after half_q
    en = 1'b0;
    @(negedge clk);
    chk("en0_audio", audio_out, 0);
`ifdef TONE_SYNTH_AMP_EN
    chk("en0_pcm", pcm, 0);
`endif
    en = 1'b1;
    count_until(1'b1, n);
    chk("resume_rise", n, 1700);

    // Asynchronous reset mid-division
    @(negedge clk);
    tone = 32'd330;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_audio", audio_out, 0);
    chk("rst_half", dut.half_q, 0);
`ifdef TONE_SYNTH_AMP_EN
    chk("rst_pcm", pcm, 0);
`endif
    @(negedge clk);
    @(negedge clk);
    chk("rst_half_held", dut.half_q, 0);
    rst_n = 1'b1;
    count_busy(n);
    chk("busy_after_rst", n, 32);
    chk("half_after_rst", dut.half_q, 1515);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
